// File: rtl/rob_id_scheduler_if.sv
// Request/grant and retire signals between requesters, the ROB and rob_id_scheduler.
// master = requester/ROB side, slave = scheduler side.
interface rob_id_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 3
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               retire;
    logic [ID_W-1:0]    retire_id;
    logic               flush;

    modport master (
        output req, retire, retire_id, flush,
        input  gnt, gnt_id
    );

    modport slave (
        input  req, retire, retire_id, flush,
        output gnt, gnt_id
    );
endinterface

// File: rtl/rob_id_scheduler.sv
// Round-robin ROB ID allocator with in-order retire tracking, flush/drain FSM and sticky error.
// Optional watchdog (sticky wdog flag, forces DRAIN) enabled by defining ROB_SCHED_WDOG_EN.
module rob_id_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DEPTH    = 8,
    parameter int ID_W     = $clog2(DEPTH),
    parameter int WDOG_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    rob_id_scheduler_if.slave  bus,
    output logic [ID_W:0]      inflight,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic               err
`ifdef ROB_SCHED_WDOG_EN
    ,
    output logic               wdog
`endif
);
    localparam int RR_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0] DEPTH_V = (ID_W + 1)'(DEPTH);
    localparam logic [RR_W:0] NREQ_V  = (RR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RUN, FULL, DRAIN} state_t;

    state_t              state, state_next;
    logic [ID_W-1:0]     alloc_ptr, head_ptr;
    logic [ID_W:0]       cnt, cnt_next;
    logic [RR_W-1:0]     rr_ptr, gnt_idx;
    logic [NUM_REQ-1:0]  gnt_vec, req_rot;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [RR_W:0]       idx_sum;
    logic                grant_en, grant, valid_retire, found;
    logic                wdog_hit;

    assign grant_en     = (state == IDLE || state == RUN) && !bus.flush;
    assign valid_retire = bus.retire && (cnt != '0);

    // Rotate requests so bit 0 is the rr_ptr requester, then pick the first set bit.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> rr_ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found   = 1'b1;
                idx_sum = {1'b0, rr_ptr} + (RR_W + 1)'(i);
            end
        end
        if (idx_sum >= NREQ_V)
            idx_sum = idx_sum - NREQ_V;
        gnt_idx = idx_sum[RR_W-1:0];
        grant   = grant_en && found;
        gnt_vec = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    assign bus.gnt    = gnt_vec;
    assign bus.gnt_id = alloc_ptr;
    assign cnt_next   = cnt + (ID_W + 1)'(grant) - (ID_W + 1)'(valid_retire);

    always_comb begin
        state_next = state;
        if (bus.flush && state != DRAIN) begin
            state_next = DRAIN;
        end else begin
            case (state)
                IDLE:    if (grant) state_next = RUN;
                RUN: begin
                    if (cnt_next == DEPTH_V)  state_next = FULL;
                    else if (cnt_next == '0)  state_next = IDLE;
                end
                FULL:    if (valid_retire) state_next = RUN;
                DRAIN:   if (cnt_next == '0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
        if (wdog_hit)
            state_next = DRAIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alloc_ptr <= '0;
            head_ptr  <= '0;
            cnt       <= '0;
            rr_ptr    <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            empty     <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            full  <= (cnt_next == DEPTH_V);
            empty <= (cnt_next == '0);
            busy  <= (state_next != IDLE);
            if (grant) begin
                alloc_ptr <= alloc_ptr + 1'b1;
                rr_ptr    <= (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (valid_retire)
                head_ptr <= head_ptr + 1'b1;
            // Out-of-order retire still advances head so the count stays consistent.
            if ((bus.retire && cnt == '0) || (valid_retire && bus.retire_id != head_ptr))
                err <= 1'b1;
        end
    end

    assign inflight = cnt;

`ifdef ROB_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC) + 1;
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_hit = (cnt != '0) && !valid_retire && (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

    // Counts stalled cycles with IDs outstanding; saturates once the limit is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            wdog     <= 1'b0;
        end else begin
            if (cnt == '0 || valid_retire)
                wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_W'(WDOG_CYC))
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_hit)
                wdog <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif
endmodule
